pipe_downsizer: RTL and testbench

Downstream width-converter stage that consumes the wide valid/ready stream produced by the s2m register slice. It serialises each IN_WIDTH beat into RATIO = IN_WIDTH/OUT_WIDTH narrow beats, lowest word first. It carries packet framing: a last flag and a partial word count on the final wide beat, so short packet tails emit only their valid words. It runs at full throughput with no bubble between consecutive wide beats.

---
 rtl/pipe_downsizer_if.sv | 30 +++
 rtl/pipe_downsizer.sv | 88 ++++++++
 tb/tb_pipe_downsizer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_downsizer_if.sv
// Wide-in / narrow-out valid/ready stream bundle for the downsizer stage.
interface pipe_downsizer_if #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 64
);
  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = $clog2(RATIO);

  logic                 pipe_in_valid;
  logic [IN_WIDTH-1:0]  pipe_in_data;
  logic                 pipe_in_last;
  logic [CNT_W-1:0]     pipe_in_cnt;
  logic                 pipe_in_ready;
  logic                 pipe_out_valid;
  logic [OUT_WIDTH-1:0] pipe_out_data;
  logic                 pipe_out_last;
  logic                 pipe_out_ready;

  // Producer of wide beats and consumer of narrow beats.
  modport master (
    output pipe_in_valid, pipe_in_data, pipe_in_last, pipe_in_cnt, pipe_out_ready,
    input  pipe_in_ready, pipe_out_valid, pipe_out_data, pipe_out_last
  );

  // The downsizer itself.
  modport slave (
    input  pipe_in_valid, pipe_in_data, pipe_in_last, pipe_in_cnt, pipe_out_ready,
    output pipe_in_ready, pipe_out_valid, pipe_out_data, pipe_out_last
  );
endinterface

// File: rtl/pipe_downsizer.sv
// Serialises each wide beat into narrow words, lowest word first, honouring
// packet tails via last/cnt. A new wide beat loads on the cycle the final word
// of the current beat leaves, so back-to-back beats stream with no bubble.
module pipe_downsizer #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 64
) (
  input logic             clk,
  input logic             reset,
  pipe_downsizer_if.slave bus
);
  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  typedef logic [RATIO-1:0][OUT_WIDTH-1:0] wide_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  wide_t            buf_q, buf_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] end_idx_q, end_idx_d;
  logic             last_q, last_d;

  logic full_c;
  logic at_end_c;
  logic in_ready_c;
  logic in_xfer_c;
  logic out_xfer_c;

  // Handshake terms; in_ready never looks at in_valid.
  assign full_c     = (state_q == ST_FULL);
  assign at_end_c   = (idx_q == end_idx_q);
  assign in_ready_c = !full_c || (bus.pipe_out_ready && at_end_c);
  assign in_xfer_c  = bus.pipe_in_valid && in_ready_c;
  assign out_xfer_c = full_c && bus.pipe_out_ready;

  // Narrow side is presented straight from the buffered beat.
  assign bus.pipe_in_ready  = in_ready_c;
  assign bus.pipe_out_valid = full_c;
  assign bus.pipe_out_data  = buf_q[idx_q];
  assign bus.pipe_out_last  = full_c && last_q && at_end_c;

  // Next-state: a wide load takes priority; it can only coincide with the final narrow word.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    end_idx_d = end_idx_q;
    last_d    = last_q;

    if (in_xfer_c) begin
      state_d   = ST_FULL;
      buf_d     = wide_t'(bus.pipe_in_data);
      idx_d     = '0;
      end_idx_d = bus.pipe_in_last ? bus.pipe_in_cnt : LAST_IDX;
      last_d    = bus.pipe_in_last;
    end else if (out_xfer_c) begin
      if (at_end_c) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end
  end

  // State register; reset drops any partially emitted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      buf_q     <= '0;
      idx_q     <= '0;
      end_idx_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      end_idx_q <= end_idx_d;
      last_q    <= last_d;
    end
  end
endmodule

// File: tb/tb_pipe_downsizer.sv
// Bench for pipe_downsizer: directed framing/timing scenarios plus a
// randomised packet stream checked against an expected-word queue.
module tb_pipe_downsizer;
  localparam int unsigned IN_W  = 256;
  localparam int unsigned OUT_W = 64;
  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned CNT_W = $clog2(RATIO);

  typedef logic [OUT_W-1:0] word_t;
  typedef logic [IN_W-1:0]  wide_t;

  typedef struct {
    wide_t            data;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } beat_t;

  typedef struct {
    word_t data;
    logic  last;
  } nword_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_downsizer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  pipe_downsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic wide_t rand_wide();
    wide_t w;
    for (int i = 0; i < int'(IN_W / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic word_t word_of(input wide_t d, input int k);
    return d[k*OUT_W +: OUT_W];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.pipe_in_valid = 1'b0;
    bus.pipe_in_data  = '0;
    bus.pipe_in_last  = 1'b0;
    bus.pipe_in_cnt   = '0;
  endtask

  task automatic drive_beat(input wide_t d, input logic last, input logic [CNT_W-1:0] cnt);
    bus.pipe_in_valid = 1'b1;
    bus.pipe_in_data  = d;
    bus.pipe_in_last  = last;
    bus.pipe_in_cnt   = cnt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    bus.pipe_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0 || bus.pipe_out_last !== 1'b0 ||
        bus.pipe_out_data !== '0 || bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%h in_ready=%b, want 0 0 0 1",
               bus.pipe_out_valid, bus.pipe_out_last, bus.pipe_out_data, bus.pipe_in_ready);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0 || bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b in_ready=%b, want 0 1",
               bus.pipe_out_valid, bus.pipe_in_ready);
    end
    next_cycle();
  endtask

  // One full non-last beat; cnt is deliberately nonzero to show it is ignored.
  task automatic test_full_beat();
    wide_t d = rand_wide();
    bus.pipe_out_ready = 1'b1;
    drive_beat(d, 1'b0, CNT_W'(1));
    @(negedge clk);
    checks++;
    if (bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_accept: in_ready=%b want 1", bus.pipe_in_ready);
    end
    next_cycle();
    drive_idle();
    for (int k = 0; k < int'(RATIO); k++) begin
      @(negedge clk);
      checks++;
      if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== word_of(d, k) ||
          bus.pipe_out_last !== 1'b0 || bus.pipe_in_ready !== (k == int'(RATIO) - 1)) begin
        errors++;
        $display("FAIL full_word%0d: valid=%b data=%h last=%b in_ready=%b, want 1 %h 0 %b",
                 k, bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last,
                 bus.pipe_in_ready, word_of(d, k), (k == int'(RATIO) - 1));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: valid=%b want 0", bus.pipe_out_valid);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    wide_t d1 = rand_wide();
    wide_t d2 = rand_wide();
    word_t ew;
    logic  acc;
    bus.pipe_out_ready = 1'b1;
    drive_beat(d1, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: in_ready=%b want 1", bus.pipe_in_ready);
    end
    next_cycle();
    drive_beat(d2, 1'b1, CNT_W'(RATIO - 1));
    for (int k = 0; k < 2 * int'(RATIO); k++) begin
      ew = (k < int'(RATIO)) ? word_of(d1, k) : word_of(d2, k - int'(RATIO));
      @(negedge clk);
      checks++;
      if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== ew ||
          bus.pipe_out_last !== (k == 2 * int'(RATIO) - 1) ||
          bus.pipe_in_ready !== (k == int'(RATIO) - 1 || k == 2 * int'(RATIO) - 1)) begin
        errors++;
        $display("FAIL b2b_word%0d: valid=%b data=%h last=%b in_ready=%b, want 1 %h %b %b",
                 k, bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last, bus.pipe_in_ready,
                 ew, (k == 2 * int'(RATIO) - 1),
                 (k == int'(RATIO) - 1 || k == 2 * int'(RATIO) - 1));
      end
      acc = bus.pipe_in_valid && bus.pipe_in_ready;
      next_cycle();
      if (acc) drive_idle();
    end
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: valid=%b want 0", bus.pipe_out_valid);
    end
    next_cycle();
  endtask

  task automatic test_cnt_zero();
    wide_t d1 = rand_wide();
    wide_t d2 = rand_wide();
    bus.pipe_out_ready = 1'b1;
    drive_beat(d1, 1'b1, '0);
    @(negedge clk);
    checks++;
    if (bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cnt0_accept: in_ready=%b want 1", bus.pipe_in_ready);
    end
    next_cycle();
    drive_beat(d2, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== word_of(d1, 0) ||
        bus.pipe_out_last !== 1'b1 || bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cnt0_single: valid=%b data=%h last=%b in_ready=%b, want 1 %h 1 1",
               bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last,
               bus.pipe_in_ready, word_of(d1, 0));
    end
    next_cycle();
    drive_idle();
    for (int k = 0; k < int'(RATIO); k++) begin
      @(negedge clk);
      checks++;
      if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== word_of(d2, k) ||
          bus.pipe_out_last !== 1'b0) begin
        errors++;
        $display("FAIL cnt0_next%0d: valid=%b data=%h last=%b, want 1 %h 0",
                 k, bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last, word_of(d2, k));
      end
      next_cycle();
    end
  endtask

  // Tail of three words under random backpressure; accepted while out_ready=0.
  task automatic test_backpressure();
    wide_t d = rand_wide();
    int    exp_k = 0;
    logic  stalled = 1'b0;
    word_t prev_data = '0;
    logic  prev_last = 1'b0;
    bus.pipe_out_ready = 1'b0;
    drive_beat(d, 1'b1, CNT_W'(2));
    @(negedge clk);
    checks++;
    if (bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept_empty: in_ready=%b want 1", bus.pipe_in_ready);
    end
    next_cycle();
    drive_idle();
    for (int cyc = 0; cyc < 64 && exp_k < 3; cyc++) begin
      bus.pipe_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== word_of(d, exp_k) ||
          bus.pipe_out_last !== (exp_k == 2)) begin
        errors++;
        $display("FAIL bp_word%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 exp_k, bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last,
                 word_of(d, exp_k), (exp_k == 2));
      end
      if (stalled) begin
        checks++;
        if (bus.pipe_out_data !== prev_data || bus.pipe_out_last !== prev_last) begin
          errors++;
          $display("FAIL bp_stall_hold: data=%h last=%b, want %h %b",
                   bus.pipe_out_data, bus.pipe_out_last, prev_data, prev_last);
        end
      end
      stalled   = !bus.pipe_out_ready;
      prev_data = bus.pipe_out_data;
      prev_last = bus.pipe_out_last;
      if (bus.pipe_out_ready) exp_k++;
      next_cycle();
    end
    checks++;
    if (exp_k != 3) begin
      errors++;
      $display("FAIL bp_timeout: words=%0d want 3", exp_k);
    end
    bus.pipe_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_word3: valid=%b data=%h want valid 0",
               bus.pipe_out_valid, bus.pipe_out_data);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    wide_t d = rand_wide();
    wide_t e = rand_wide();
    bus.pipe_out_ready = 1'b1;
    drive_beat(d, 1'b0, '0);
    next_cycle();
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== word_of(d, k)) begin
        errors++;
        $display("FAIL rmid_pre%0d: valid=%b data=%h, want 1 %h",
                 k, bus.pipe_out_valid, bus.pipe_out_data, word_of(d, k));
      end
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0 || bus.pipe_out_last !== 1'b0 ||
        bus.pipe_out_data !== '0 || bus.pipe_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_reset: valid=%b last=%b data=%h in_ready=%b, want 0 0 0 1",
               bus.pipe_out_valid, bus.pipe_out_last, bus.pipe_out_data, bus.pipe_in_ready);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_residual: valid=%b data=%h want valid 0",
               bus.pipe_out_valid, bus.pipe_out_data);
    end
    next_cycle();
    drive_beat(e, 1'b0, '0);
    next_cycle();
    drive_idle();
    for (int k = 0; k < int'(RATIO); k++) begin
      @(negedge clk);
      checks++;
      if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== word_of(e, k) ||
          bus.pipe_out_last !== 1'b0) begin
        errors++;
        $display("FAIL rmid_post%0d: valid=%b data=%h last=%b, want 1 %h 0",
                 k, bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last, word_of(e, k));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (bus.pipe_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_drained: valid=%b want 0", bus.pipe_out_valid);
    end
    next_cycle();
  endtask

  // Random packets; the expected word list follows directly from each beat's framing.
  task automatic test_random_packets();
    beat_t  beats[$];
    nword_t exp_q[$];
    beat_t  bt;
    nword_t nw;
    int     nb;
    int     nwords;
    int     cyc = 0;
    logic   stalled = 1'b0;
    word_t  prev_data = '0;
    logic   prev_last = 1'b0;
    logic   in_acc;

    for (int p = 0; p < 1000; p++) begin
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        bt.data = rand_wide();
        bt.last = (b == nb - 1);
        bt.cnt  = CNT_W'($urandom_range(0, RATIO - 1));
        beats.push_back(bt);
        nwords = bt.last ? int'(bt.cnt) + 1 : int'(RATIO);
        for (int k = 0; k < nwords; k++) begin
          nw.data = word_of(bt.data, k);
          nw.last = bt.last && (k == nwords - 1);
          exp_q.push_back(nw);
        end
      end
    end

    while ((beats.size() > 0 || exp_q.size() > 0) && cyc < 60000) begin
      cyc++;
      if (beats.size() > 0 && $urandom_range(0, 3) != 0) begin
        drive_beat(beats[0].data, beats[0].last, beats[0].cnt);
      end else begin
        bus.pipe_in_valid = 1'b0;
        bus.pipe_in_data  = 'x;
        bus.pipe_in_last  = 1'b0;
        bus.pipe_in_cnt   = 'x;
      end
      bus.pipe_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      checks++;
      if ($isunknown({bus.pipe_out_valid, bus.pipe_out_last, bus.pipe_in_ready})) begin
        errors++;
        $display("FAIL rnd_unknown: valid=%b last=%b in_ready=%b",
                 bus.pipe_out_valid, bus.pipe_out_last, bus.pipe_in_ready);
      end
      if (bus.pipe_out_valid !== 1'b1) begin
        checks++;
        if (bus.pipe_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL rnd_empty_ready: in_ready=%b want 1", bus.pipe_in_ready);
        end
      end
      if (stalled) begin
        checks++;
        if (bus.pipe_out_valid !== 1'b1 || bus.pipe_out_data !== prev_data ||
            bus.pipe_out_last !== prev_last) begin
          errors++;
          $display("FAIL rnd_stall_hold: valid=%b data=%h last=%b, want 1 %h %b",
                   bus.pipe_out_valid, bus.pipe_out_data, bus.pipe_out_last,
                   prev_data, prev_last);
        end
      end
      if (bus.pipe_out_valid === 1'b1 && bus.pipe_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra_word: data=%h last=%b, want none",
                   bus.pipe_out_data, bus.pipe_out_last);
        end else begin
          nw = exp_q.pop_front();
          if (bus.pipe_out_data !== nw.data || bus.pipe_out_last !== nw.last) begin
            errors++;
            $display("FAIL rnd_word: data=%h last=%b, want %h %b",
                     bus.pipe_out_data, bus.pipe_out_last, nw.data, nw.last);
          end
        end
      end
      stalled   = (bus.pipe_out_valid === 1'b1) && !bus.pipe_out_ready;
      prev_data = bus.pipe_out_data;
      prev_last = bus.pipe_out_last;
      in_acc    = bus.pipe_in_valid && (bus.pipe_in_ready === 1'b1);
      next_cycle();
      if (in_acc) void'(beats.pop_front());
    end
    checks++;
    if (beats.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_leftover: beats=%0d words=%0d, want 0 0", beats.size(), exp_q.size());
    end
    drive_idle();
    bus.pipe_out_ready = 1'b1;
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    bus.pipe_out_ready = 1'b1;
    next_cycle();
    test_reset();
    test_full_beat();
    test_back_to_back();
    test_cnt_zero();
    test_backpressure();
    test_reset_mid();
    test_random_packets();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
